// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave controller: state codes, BCD digit type,
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high) and the seconds-tens borrow value.
package microwave_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SET   = 3'd1;
   localparam logic [2:0] ST_COOK  = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam bcd_t SEC_TENS_BORROW = 4'd5;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to seven-segment pattern, purely combinational; non-BCD codes blank the digit.
module seg7_decoder
   import microwave_pkg::*;
(
   input  bcd_t       digit,
   output logic [6:0] seg
);

   always_comb begin
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/microwave_ctrl_gen.sv
// Microwave controller: keypad time entry, BCD countdown, magnetron enable and done flag.
// Defining POWER_LEVEL_EN adds a ten-step power level applied as a 10-second duty cycle.
module microwave_ctrl_gen
   import microwave_pkg::*;
#(
   parameter int TICK_DIV   = 100,
   parameter int MIN_DIGITS = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [9:0]              kbd,
   input  logic                    startn,
   input  logic                    stopn,
   input  logic                    clearn,
   input  logic                    powern,
   input  logic                    door_closed,
   output logic [6:0]              sec_ones_seg,
   output logic [6:0]              sec_tens_seg,
   output logic [7*MIN_DIGITS-1:0] min_segs,
   output logic                    mag_on,
   output logic                    done
);

   localparam int NDIG = MIN_DIGITS + 2;
   localparam int TW   = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [2:0]    state, state_nxt;
   logic [TW-1:0] tick, tick_nxt;
   bcd_t          digs [NDIG];
   bcd_t          digs_nxt [NDIG];
   bcd_t          shl [NDIG];
   bcd_t          dec [NDIG];
   bcd_t          key;
   logic [9:0]    kbd_q;
   logic          start_q, stop_q, clear_q;
   logic          start_ev, stop_ev, clear_ev, dig_ev, key_onehot;
   logic          shl_zero, dec_zero, borrow, sec_wrap, clr_time;
   logic          power_exit, duty_ok;

   assign start_ev   = start_q & ~startn;
   assign stop_ev    = stop_q & ~stopn;
   assign clear_ev   = clear_q & ~clearn;
   assign key_onehot = (kbd != '0) && ((kbd & (kbd - 10'd1)) == '0);
   assign dig_ev     = (kbd_q == '0) && key_onehot;

   // Candidate times: keypad shift (top digit falls off) and one-second decrement.
   always_comb begin
      key = '0;
      for (int i = 0; i < 10; i++)
         if (kbd[i]) key = 4'(i);
      shl[0]   = key;
      shl_zero = (key == '0);
      for (int i = 1; i < NDIG; i++) begin
         shl[i]   = digs[i-1];
         shl_zero = shl_zero && (digs[i-1] == '0);
      end
      borrow   = 1'b1;
      dec_zero = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         dec[i] = digs[i];
         if (borrow) begin
            if (digs[i] == '0) begin
               dec[i] = (i == 1) ? SEC_TENS_BORROW : 4'd9;
            end else begin
               dec[i] = digs[i] - 4'd1;
               borrow = 1'b0;
            end
         end
         dec_zero = dec_zero && (dec[i] == '0);
      end
   end

   always_comb begin
      state_nxt = state;
      tick_nxt  = tick;
      digs_nxt  = digs;
      sec_wrap  = 1'b0;
      clr_time  = 1'b0;
      if (clear_ev) begin
         state_nxt = ST_IDLE;
         clr_time  = 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_SET: begin
               if (stop_ev) begin
                  state_nxt = ST_IDLE;
                  clr_time  = 1'b1;
               end else if (state == ST_SET && start_ev && door_closed) begin
                  state_nxt = ST_COOK;
                  tick_nxt  = '0;
               end else if (dig_ev) begin
                  digs_nxt  = shl;
                  state_nxt = shl_zero ? ST_IDLE : ST_SET;
               end
            end
            ST_COOK: begin
               if (stop_ev || !door_closed) begin
                  state_nxt = ST_PAUSE;
               end else if (tick == TICK_LAST) begin
                  tick_nxt = '0;
                  sec_wrap = 1'b1;
                  digs_nxt = dec;
                  if (dec_zero) state_nxt = ST_DONE;
               end else begin
                  tick_nxt = tick + TW'(1);
               end
            end
            ST_PAUSE: begin
               if (stop_ev) begin
                  state_nxt = ST_IDLE;
                  clr_time  = 1'b1;
               end else if (start_ev && door_closed) begin
                  state_nxt = ST_COOK;
                  tick_nxt  = '0;
               end
            end
            ST_DONE: begin
               if (stop_ev || start_ev || dig_ev || power_exit || !door_closed)
                  state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
               clr_time  = 1'b1;
            end
         endcase
      end
      if (clr_time)
         for (int i = 0; i < NDIG; i++) digs_nxt[i] = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         tick    <= '0;
         kbd_q   <= '0;
         start_q <= 1'b1;
         stop_q  <= 1'b1;
         clear_q <= 1'b1;
         for (int i = 0; i < NDIG; i++) digs[i] <= '0;
      end else begin
         state   <= state_nxt;
         tick    <= tick_nxt;
         kbd_q   <= kbd;
         start_q <= startn;
         stop_q  <= stopn;
         clear_q <= clearn;
         digs    <= digs_nxt;
      end
   end

`ifdef POWER_LEVEL_EN
   logic [3:0] level, phase;
   logic       power_q, power_ev;

   assign power_ev   = power_q & ~powern;
   assign power_exit = power_ev;
   assign duty_ok    = (phase < level);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level   <= 4'd10;
         phase   <= '0;
         power_q <= 1'b1;
      end else begin
         power_q <= powern;
         if (power_ev && (state == ST_IDLE || state == ST_SET))
            level <= (level == 4'd1) ? 4'd10 : level - 4'd1;
         if (state != ST_COOK && state_nxt == ST_COOK)
            phase <= '0;
         else if (sec_wrap)
            phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
      end
   end
`else
   logic unused_powern;
   assign unused_powern = powern;
   assign power_exit    = 1'b0;
   assign duty_ok       = 1'b1;
`endif

   // Door interlock is combinational so opening the door kills the magnetron immediately.
   assign mag_on = door_closed && (state == ST_COOK) && duty_ok;
   assign done   = (state == ST_DONE);

   seg7_decoder u_sec_ones (.digit(digs[0]), .seg(sec_ones_seg));
   seg7_decoder u_sec_tens (.digit(digs[1]), .seg(sec_tens_seg));

   for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min
      seg7_decoder u_min (.digit(digs[g+2]), .seg(min_segs[7*g +: 7]));
   end

endmodule

// File: tb/tb_microwave_ctrl_gen.sv
// Bench for microwave_ctrl_gen: a default instance and a two-minute-digit, fast-tick instance
// share one stimulus stream; every cycle both are compared against a digit-arithmetic model.
module tb_microwave_ctrl_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  kbd = '0;
   logic        startn = 1'b1, stopn = 1'b1, clearn = 1'b1, powern = 1'b1;
   logic        door_closed = 1'b1;
   logic [6:0]  so0, st0, ms0, so1, st1;
   logic [13:0] ms1;
   logic        mag0, done0, mag1, done1;

   int checks = 0;
   int errors = 0;

`ifdef POWER_LEVEL_EN
   localparam bit PW = 1'b1;
`else
   localparam bit PW = 1'b0;
`endif

   localparam int M_IDLE = 0, M_SET = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

   // Model: seconds ones/tens as digits, minutes as a plain integer.
   int st [2], ones [2], tens [2], mins [2], tk [2], level [2], phase [2];
   logic       p_start, p_stop, p_clear, p_power;
   logic [9:0] p_kbd;

   always #5 clk = ~clk;

   microwave_ctrl_gen dut (
      .clk(clk), .reset(reset), .kbd(kbd), .startn(startn), .stopn(stopn),
      .clearn(clearn), .powern(powern), .door_closed(door_closed),
      .sec_ones_seg(so0), .sec_tens_seg(st0), .min_segs(ms0), .mag_on(mag0), .done(done0));

   microwave_ctrl_gen #(.TICK_DIV(4), .MIN_DIGITS(2)) dut2 (
      .clk(clk), .reset(reset), .kbd(kbd), .startn(startn), .stopn(stopn),
      .clearn(clearn), .powern(powern), .door_closed(door_closed),
      .sec_ones_seg(so1), .sec_tens_seg(st1), .min_segs(ms1), .mag_on(mag1), .done(done1));

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic int tdiv(input int k);
      return (k == 0) ? 100 : 4;
   endfunction

   function automatic int mmod(input int k);
      return (k == 0) ? 10 : 100;
   endfunction

   function automatic bit tzero(input int k);
      return ones[k] == 0 && tens[k] == 0 && mins[k] == 0;
   endfunction

   function automatic bit exp_mag(input int k);
      return door_closed && st[k] == M_COOK && phase[k] < level[k];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         st[k] = M_IDLE; ones[k] = 0; tens[k] = 0; mins[k] = 0;
         tk[k] = 0; level[k] = 10; phase[k] = 0;
      end
      p_start = 1'b1; p_stop = 1'b1; p_clear = 1'b1; p_power = 1'b1; p_kbd = '0;
   endtask

   task automatic m_clr(input int k);
      ones[k] = 0; tens[k] = 0; mins[k] = 0; st[k] = M_IDLE;
   endtask

   task automatic m_dec(input int k);
      if (ones[k] > 0) ones[k]--;
      else begin
         ones[k] = 9;
         if (tens[k] > 0) tens[k]--;
         else begin
            tens[k] = 5;
            mins[k]--;
         end
      end
   endtask

   task automatic m_cook(input int k);
      st[k] = M_COOK; tk[k] = 0; phase[k] = 0;
   endtask

   // One rising edge of the reference behaviour, using the inputs currently applied.
   task automatic m_step();
      bit ec, es, eg, ep, ed;
      int d;
      ec = p_clear && !clearn;
      es = p_stop && !stopn;
      eg = p_start && !startn;
      ep = PW && p_power && !powern;
      ed = (p_kbd == 10'd0) && ($countones(kbd) == 1);
      d = 0;
      for (int i = 0; i < 10; i++) if (kbd[i]) d = i;
      for (int k = 0; k < 2; k++) begin
         if (ep && (st[k] == M_IDLE || st[k] == M_SET))
            level[k] = (level[k] == 1) ? 10 : level[k] - 1;
         if (ec) m_clr(k);
         else case (st[k])
            M_IDLE, M_SET: begin
               if (es) m_clr(k);
               else if (st[k] == M_SET && eg && door_closed) m_cook(k);
               else if (ed) begin
                  mins[k] = (mins[k] * 10 + tens[k]) % mmod(k);
                  tens[k] = ones[k];
                  ones[k] = d;
                  st[k] = tzero(k) ? M_IDLE : M_SET;
               end
            end
            M_COOK: begin
               if (es || !door_closed) st[k] = M_PAUSE;
               else if (tk[k] == tdiv(k) - 1) begin
                  tk[k] = 0;
                  phase[k] = (phase[k] + 1) % 10;
                  m_dec(k);
                  if (tzero(k)) st[k] = M_DONE;
               end else tk[k]++;
            end
            M_PAUSE: begin
               if (es) m_clr(k);
               else if (eg && door_closed) m_cook(k);
            end
            default: if (es || eg || ep || ed || !door_closed) st[k] = M_IDLE;
         endcase
      end
      p_start = startn; p_stop = stopn; p_clear = clearn; p_power = powern; p_kbd = kbd;
   endtask

   task automatic check_all();
      chk("mag_on_a", 32'(mag0), 32'(exp_mag(0)));
      chk("done_a", 32'(done0), 32'(st[0] == M_DONE));
      chk("sec_ones_a", 32'(so0), 32'(seg(ones[0])));
      chk("sec_tens_a", 32'(st0), 32'(seg(tens[0])));
      chk("min_a", 32'(ms0), 32'(seg(mins[0])));
      chk("mag_on_b", 32'(mag1), 32'(exp_mag(1)));
      chk("done_b", 32'(done1), 32'(st[1] == M_DONE));
      chk("sec_ones_b", 32'(so1), 32'(seg(ones[1])));
      chk("sec_tens_b", 32'(st1), 32'(seg(tens[1])));
      chk("min_b", 32'(ms1), 32'({seg(mins[1] / 10), seg(mins[1] % 10)}));
   endtask

   // Entered shortly after a rising edge; checks mid-cycle, then advances one edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         #2;
         check_all();
         @(posedge clk);
         m_step();
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_mag_a", 32'(mag0), 32'd0);
      chk("rst_done_a", 32'(done0), 32'd0);
      chk("rst_segs_a", 32'({so0, st0, ms0}), 32'({3{7'b0111111}}));
      chk("rst_mag_b", 32'(mag1), 32'd0);
      chk("rst_segs_b", 32'({so1, st1, ms1}), 32'({4{7'b0111111}}));
      m_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic press_digit(input int d);
      kbd = 10'd1 << d; cyc(1); kbd = '0; cyc(1);
   endtask
   task automatic press_start();
      startn = 1'b0; cyc(1); startn = 1'b1; cyc(1);
   endtask
   task automatic press_stop();
      stopn = 1'b0; cyc(1); stopn = 1'b1; cyc(1);
   endtask
   task automatic press_clear();
      clearn = 1'b0; cyc(1); clearn = 1'b1; cyc(1);
   endtask
   task automatic press_power();
      powern = 1'b0; cyc(1); powern = 1'b1; cyc(1);
   endtask

   initial begin
      int r;
      #1;
      do_reset();
      cyc(3);

      // 0:12 full countdown on the default instance.
      press_digit(1); press_digit(2);
      chk("entry_12_ones", 32'(so0), 32'(7'b1011011));
      chk("entry_12_tens", 32'(st0), 32'(7'b0000110));
      press_start();
      cyc(1198);
      chk("cook_last_sec_mag", 32'(mag0), 32'd1);
      chk("cook_last_sec_ones", 32'(so0), 32'(7'b0000110));
      cyc(1);
      chk("cook_done", 32'(done0), 32'd1);
      chk("cook_done_mag", 32'(mag0), 32'd0);
      press_clear();

      // 0:35, stop after five seconds, stop again.
      press_digit(3); press_digit(5); press_start();
      cyc(499);
      stopn = 1'b0; cyc(1); stopn = 1'b1;
      chk("pause_mag", 32'(mag0), 32'd0);
      chk("pause_time", 32'({st0, so0}), 32'({7'b1001111, 7'b0111111}));
      cyc(150);
      chk("pause_hold", 32'({st0, so0}), 32'({7'b1001111, 7'b0111111}));
      press_stop();
      chk("stop_idle", 32'({st0, so0}), 32'({7'b0111111, 7'b0111111}));

      // 1:29, door opened at 1:26, resumed.
      press_digit(1); press_digit(2); press_digit(9); press_start();
      cyc(299);
      door_closed = 1'b0;
      #1;
      chk("door_mag_now", 32'(mag0), 32'd0);
      cyc(50);
      chk("door_hold", 32'({ms0, st0, so0}), 32'({7'b0000110, 7'b1011011, 7'b1111101}));
      door_closed = 1'b1;
      press_start();
      cyc(98);
      chk("resume_pre", 32'(so0), 32'(7'b1111101));
      cyc(1);
      chk("resume_125", 32'(so0), 32'(7'b1101101));
      press_clear();

      // Start at zero, non-one-hot keys, clear beating start.
      press_start();
      chk("start_zero_mag", 32'(mag0), 32'd0);
      kbd = 10'b0000000110; cyc(2); kbd = '0; cyc(1);
      chk("multi_key_ign", 32'(so0), 32'(7'b0111111));
      press_digit(4);
      clearn = 1'b0; startn = 1'b0; cyc(1); clearn = 1'b1; startn = 1'b1; cyc(1);
      chk("clear_vs_start", 32'(so0), 32'(7'b0111111));
      cyc(110);
      chk("clear_vs_start_mag", 32'(mag0), 32'd0);

      // 10:00 on the two-digit instance; the one-digit instance drops the top digit.
      press_digit(1); press_digit(0); press_digit(0); press_digit(0);
      chk("ten_min_b", 32'({ms1, st1, so1}), 32'({7'b0000110, {3{7'b0111111}}}));
      chk("discard_a", 32'({ms0, st0, so0}), 32'({3{7'b0111111}}));
      press_start();
      cyc(3);
      chk("ten_min_dec_b", 32'({ms1, st1, so1}),
          32'({7'b0111111, 7'b1101111, 7'b1101101, 7'b1101111}));
      press_clear();

`ifdef POWER_LEVEL_EN
      repeat (7) press_power();
      press_digit(2); press_digit(0); press_start();
      chk("pl_on_phase0", 32'(mag0), 32'd1);
      cyc(300);
      chk("pl_off_phase3", 32'(mag0), 32'd0);
      cyc(700);
      chk("pl_on_phase0b", 32'(mag0), 32'd1);
`else
      repeat (3) press_power();
      press_digit(2); press_digit(0); press_start();
      cyc(300);
      chk("full_duty", 32'(mag0), 32'd1);
`endif
      do_reset();
      cyc(2);

      for (int n = 0; n < 90; n++) begin
         r = int'($urandom_range(0, 15));
         case (r)
            0, 1, 2, 3, 4, 5: press_digit(int'($urandom_range(0, 9)));
            6, 7: press_start();
            8: press_stop();
            9: press_clear();
            10: press_power();
            11: begin door_closed = ~door_closed; cyc(1); end
            12: begin kbd = 10'($urandom); cyc(1); kbd = '0; cyc(1); end
            default: cyc(int'($urandom_range(1, 250)));
         endcase
      end
      door_closed = 1'b1;
      cyc(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/microwave_ctrl_gen.md
MICROWAVE_CTRL_GEN -- requirements
Module: microwave_ctrl_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100: clk cycles per countdown second, range 2..2^16.
REQ-002 SHALL have parameter MIN_DIGITS, default 1: number of BCD minute digits, range 1..2.
REQ-003 SHALL have port clk  input  1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port kbd  input  10: digit keys, bit n = digit n, active-high.
REQ-006 SHALL have ports startn, stopn, clearn, powern  input  1 each: buttons, active-low.
REQ-007 SHALL have port door_closed  input  1: 1 = door closed.
REQ-008 SHALL have ports sec_ones_seg, sec_tens_seg  output  7 each: segment patterns {g,f,e,d,c,b,a}, active-high.
REQ-009 SHALL have port min_segs  output  7*MIN_DIGITS: minute digit segments, least significant digit in bits [6:0].
REQ-010 SHALL have port mag_on  output  1: magnetron enable.
REQ-011 SHALL have port done  output  1: cook-complete indicator.

Function
REQ-012 Button press events SHALL be the falling edge of each n-input, detected against its previous-cycle sample; kbd events SHALL be a 0-to-nonzero transition of kbd; a non-one-hot kbd value SHALL be ignored.
REQ-013 States SHALL be IDLE (time 0), SET (time nonzero, not cooking), COOK, PAUSE, DONE.
REQ-014 A digit event in IDLE or SET SHALL shift time left one BCD digit: new digit into sec_ones, sec_ones to sec_tens, sec_tens to min0, min0 to min1; the top digit is discarded; then IDLE goes to SET if the result is nonzero.
REQ-015 Digit events in COOK, PAUSE or DONE SHALL be ignored.
REQ-016 A start event in SET or PAUSE with door_closed=1 SHALL enter COOK and reset the tick counter to 0; start is ignored in IDLE, in DONE, or with the door open.
REQ-017 In COOK the tick counter SHALL count 0..TICK_DIV-1; on wrap, time SHALL decrement once.
REQ-018 Decrement rule: sec_ones 0 borrows to 9; sec_tens 0 borrows to 5; minute digits borrow in BCD. Entered sec_tens values 6..9 SHALL be counted down as entered.
REQ-019 The decrement that reaches all-zero time SHALL enter DONE on the same edge.
REQ-020 In COOK, stop or door_closed=0 SHALL enter PAUSE and retain time.
REQ-021 Stop in SET or PAUSE SHALL clear time and enter IDLE.
REQ-022 Clear in any state SHALL clear time and enter IDLE.
REQ-023 done SHALL be 1 only in DONE; any button, digit or door-open event in DONE SHALL enter IDLE; a digit event there SHALL be dropped.
REQ-024 Simultaneous-event priority: clear > stop > door open > start > digit.
REQ-025 mag_on SHALL be 0 in every cycle with door_closed=0, combinationally, and otherwise 1 only in COOK (subject to REQ-030).
REQ-026 Segment outputs SHALL decode the current time digits combinationally, with leading zeros shown, and SHALL be updated on the edge that changes time.

Reset
REQ-027 reset=1 SHALL asynchronously force: state IDLE, time 0, tick counter 0, edge-detect registers to released, and power level 10.
REQ-028 While reset=1 the outputs SHALL be mag_on=0, done=0, and all digits showing "0" (7'b0111111).
REQ-029 Reset asserted mid-COOK SHALL deassert mag_on in the same cycle.

Configuration
REQ-030 With POWER_LEVEL_EN defined:
- a powern event in IDLE or SET cycles the level 10, 9, ..., 1, then back to 10;
- a 0..9 seconds-phase counter runs in COOK, reset on COOK entry;
- mag_on SHALL be 1 only while phase < level.
REQ-031 Without POWER_LEVEL_EN, powern SHALL be ignored, no level or phase logic SHALL exist, and mag_on SHALL follow REQ-025 at full duty.

Structure
REQ-032 Package microwave_pkg SHALL hold the state encoding, the BCD digit type, the segment constants for digits 0-9, and the sec_tens borrow value 5.
REQ-033 Sub-module seg7_decoder (4-bit BCD in, 7-bit segments out) SHALL be instanced once per displayed digit.

Verification
REQ-034 Defaults: reset; digits 1, 2; start; hold 12*100 cycles -> mag_on=1 throughout, display counts 0:12 to 0:00, then done=1 and mag_on=0.
REQ-035 Digits 3, 5; start; after 5 s press stop -> PAUSE at 0:30 with mag_on=0; stop again -> IDLE at 0:00.
REQ-036 Digits 1, 2, 9; start; at 1:26 open the door -> mag_on=0 the same cycle, display holds 1:26; close door and start -> countdown resumes 1:25 after 100 cycles.
REQ-037 Start with time 0 -> stays IDLE; kbd=10'b0000000110 -> ignored; clear asserted together with start in SET -> IDLE, time 0.
REQ-038 MIN_DIGITS=2: enter 1, 0, 0, 0 -> 10:00; decrement -> 09:59.
REQ-039 POWER_LEVEL_EN: set level 3; cook 0:20 -> mag_on high for 3 s of each 10 s; reset mid-COOK -> mag_on=0 immediately.
